// File: rtl/pdm_dac_pkg.sv
// Shared types and helpers for the multi-channel PDM/PWM level DAC.
package pdm_dac_pkg;

  localparam int WIDTH_DEF = 5;

  // Modulator mode, captured once per frame.
  typedef enum logic {
    MODE_PDM = 1'b0,
    MODE_PWM = 1'b1
  } mode_e;

  typedef logic [WIDTH_DEF-1:0] level_t;

  // Width of a channel select; a single channel still gets one select bit.
  function automatic int ch_bits(int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pdm_pwm_multi_dac_if.sv
// Narrow channel-addressed level write port.
interface pdm_pwm_multi_dac_if #(
  parameter int WIDTH   = 5,
  parameter int CH_BITS = 2
);

  logic               wr_en;
  logic [CH_BITS-1:0] wr_ch;
  logic [WIDTH-1:0]   wr_data;

  modport master (output wr_en, wr_ch, wr_data);
  modport slave  (input  wr_en, wr_ch, wr_data);

endinterface

// File: rtl/pdm_pwm_channel.sv
// One output channel: active level, first-order PDM accumulator, PWM compare
// and the registered output bit.
module pdm_pwm_channel
  import pdm_dac_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  mode_e            mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] frame_cnt,
  input  logic             load,
  input  logic [WIDTH-1:0] load_level,
  output logic             dac
);

  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;

  // Accumulator step; the carry out is the PDM output bit.
  always_comb begin
    {carry, acc_next} = {1'b0, acc} + {1'b0, active};
  end

  // Active level register, replaced only when the top hands over a new level.
  // NOTE: state is written with <= so every flop samples pre-edge values;
  // a blocking = here would let later logic in the same edge see new values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= '0;
    end else if (load) begin
      active <= load_level;
    end
  end

  // Accumulator runs freely in PDM, holds in PWM, clears on a mode change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (mode == MODE_PDM) begin
      acc <= acc_next;
    end
  end

  // Registered output: carry in PDM, counter compare in PWM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dac <= 1'b0;
    end else if (mode == MODE_PWM) begin
      dac <= (frame_cnt < active);
    end else begin
      dac <= carry;
    end
  end

endmodule

// File: rtl/pdm_pwm_multi_dac.sv
// Multi-channel PDM/PWM level DAC: frame counter, write decode, shadow and
// pending registers, per-frame mode capture and the channel array.
module pdm_pwm_multi_dac
  import pdm_dac_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int CHANNELS    = 4,
  parameter int CH_BITS     = ch_bits(CHANNELS),
  parameter bit SYNC_UPDATE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pdm_pwm_multi_dac_if.slave   wr,
  input  logic                 mode_pwm,
  output logic [CHANNELS-1:0]  dac_out,
  output logic                 frame_sync,
  output logic [CHANNELS-1:0]  pending
);

  localparam int              CH_N     = CHANNELS;
  localparam logic [CH_BITS:0] CH_LIMIT = CH_N[CH_BITS:0];

  logic [WIDTH-1:0]    frame_cnt;
  logic                boundary;
  mode_e               mode_q;
  logic                mode_clr;
  logic                wr_ok;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] pending_q;
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [CHANNELS-1:0] load;
  logic [WIDTH-1:0]    load_level [CHANNELS];

  assign boundary = (frame_cnt == '1);
  assign mode_clr = boundary && (mode_e'(mode_pwm) != mode_q);
  assign wr_ok    = wr.wr_en && ({1'b0, wr.wr_ch} < CH_LIMIT);
  assign pending  = pending_q;

  // Gated by reset_n so the pulse stays low while reset is held even though
  // the counter already sits at zero.
  assign frame_sync = reset_n && (frame_cnt == '0);

  // Free-running frame counter and mode capture at the frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      mode_q    <= MODE_PDM;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
      if (boundary) begin
        mode_q <= mode_e'(mode_pwm);
      end
    end
  end

  // Write address decode; out-of-range channels select nothing.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_ok && (wr.wr_ch == CH_BITS'(i));
    end
  end

  // Shadow capture and pending flags for deferred application.
  // NOTE: the shadow array is small and reset explicitly so no stale level
  // can survive a reset; larger storage would normally be left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
      end
    end else if (SYNC_UPDATE) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary) begin
          pending_q[i] <= 1'b0;
        end else if (wr_hit[i]) begin
          shadow[i]    <= wr.wr_data;
          pending_q[i] <= 1'b1;
        end
      end
    end
  end

  // Choose when and what each channel loads into its active level.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load_level[i] = wr.wr_data;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (SYNC_UPDATE) begin
        // A write landing on the boundary bypasses the shadow.
        load[i] = boundary && (wr_hit[i] || pending_q[i]);
        if (!wr_hit[i]) begin
          load_level[i] = shadow[i];
        end
      end else begin
        load[i] = wr_hit[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pdm_pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .mode       (mode_q),
      .acc_clr    (mode_clr),
      .frame_cnt  (frame_cnt),
      .load       (load[g]),
      .load_level (load_level[g]),
      .dac        (dac_out[g])
    );
  end

endmodule

// File: tb/tb_pdm_pwm_multi_dac.sv
// Scoreboard bench for pdm_pwm_multi_dac (WIDTH=5, CHANNELS=4, 3-bit select).
module tb_pdm_pwm_multi_dac;

  localparam int WIDTH    = 5;
  localparam int CHANNELS = 4;
  localparam int CH_BITS  = 3;
  localparam int FRAME    = 32;

  typedef struct {
    int          frame;
    int          ch;
    bit          is_pattern;
    logic [31:0] value;
    string       name;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                mode_pwm = 1'b0;
  logic [CHANNELS-1:0] dac_out;
  logic                frame_sync;
  logic [CHANNELS-1:0] pending;

  int          checks = 0;
  int          failures = 0;
  int          tb_cyc;
  exp_t        exp_q[$];
  int          ones [CHANNELS];
  logic [31:0] pat0;

  pdm_pwm_multi_dac_if #(.WIDTH(WIDTH), .CH_BITS(CH_BITS)) wr_bus ();

  pdm_pwm_multi_dac #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .CH_BITS    (CH_BITS),
    .SYNC_UPDATE(1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (wr_bus),
    .mode_pwm  (mode_pwm),
    .dac_out   (dac_out),
    .frame_sync(frame_sync),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Bench-side cycle count since reset release; equals the expected frame_cnt.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t cyc=%0d)", name, act, req, $time, tb_cyc);
    end
  endtask

  task automatic expect_frame(int frame, int ch, bit is_pattern, logic [31:0] value, string name);
    exp_t e;
    e.frame = frame;
    e.ch = ch;
    e.is_pattern = is_pattern;
    e.value = value;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_ones(int frame, int l0, int l1, int l2, int l3, string tag);
    expect_frame(frame, 0, 1'b0, l0, {tag, "_ones_ch0"});
    expect_frame(frame, 1, 1'b0, l1, {tag, "_ones_ch1"});
    expect_frame(frame, 2, 1'b0, l2, {tag, "_ones_ch2"});
    expect_frame(frame, 3, 1'b0, l3, {tag, "_ones_ch3"});
  endtask

  // Compare every queued expectation belonging to the frame just completed.
  task automatic finalize(int f);
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0 && exp_q[0].frame <= f) begin
      e = exp_q.pop_front();
      if (e.frame < f) begin
        checks++;
        failures++;
        $display("FAIL %s stale: expected frame %0d never evaluated, now frame %0d", e.name, e.frame, f);
      end else begin
        act = e.is_pattern ? pat0 : 32'(ones[e.ch]);
        check(e.name, act, e.value);
      end
    end
  endtask

  // Monitor: collects each frame's output window and pops the scoreboard at
  // every frame start. Window of frame n = outputs from frame_cnt 1..31 then 0.
  initial begin
    int fc;
    pat0 = '0;
    foreach (ones[i]) ones[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pat0 = '0;
        foreach (ones[i]) ones[i] = 0;
      end else begin
        fc = tb_cyc % FRAME;
        for (int c = 0; c < CHANNELS; c++) ones[c] += int'(dac_out[c]);
        pat0[(fc + FRAME - 1) % FRAME] = dac_out[0];
        if (fc == 0) begin
          if (tb_cyc > 0) begin
            check("frame_sync_start", frame_sync, 1);
            finalize(tb_cyc / FRAME - 1);
          end
          pat0 = '0;
          foreach (ones[i]) ones[i] = 0;
        end else if (fc == FRAME / 2) begin
          check("frame_sync_mid", frame_sync, 0);
        end
      end
    end
  end

  task automatic wait_cyc(int c);
    while (tb_cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(int ch, int data);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_ch   = CH_BITS'(ch);
    wr_bus.wr_data = WIDTH'(data);
    @(posedge clk);
    #1;
    wr_bus.wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", tb_cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_ch   = '0;
    wr_bus.wr_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dac_out", dac_out, 0);
    check("rst_pending", pending, 0);
    check("rst_frame_sync", frame_sync, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_frame_sync", frame_sync, 1);

    // Test 1: ch0=8 waits for the boundary, then one pulse every 4 cycles
    expect_ones(0, 0, 0, 0, 0, "f0");
    wait_cyc(2);
    write(0, 8);
    check("t1_pending", pending, 4'b0001);
    expect_frame(1, 0, 1'b1, 32'h8888_8888, "t1_pat_ch0");
    expect_ones(1, 8, 0, 0, 0, "t1_f1");
    wait_cyc(33);
    check("t1_pending_applied", pending, 0);

    // Test 2: three consecutive writes apply on one boundary
    wait_cyc(40);
    write(1, 'h1a);
    write(2, 'h1f);
    write(3, 0);
    check("t2_pending", pending, 4'b1110);
    expect_ones(2, 8, 26, 31, 0, "t2_f2");

    // Test 3: PWM requested mid-frame; PDM continues until the boundary
    wait_cyc(70);
    mode_pwm = 1'b1;
    wait_cyc(72);
    write(0, 'h0f);
    check("t3_pending", pending, 4'b0001);
    expect_frame(2, 0, 1'b1, 32'h8888_8888, "t3_pdm_pat_ch0");
    expect_frame(3, 0, 1'b1, 32'h0000_7fff, "t3_pwm_pat_ch0");
    expect_ones(3, 15, 26, 31, 0, "t3_f3");
    wait_cyc(100);
    mode_pwm = 1'b0;

    // Test 4: write exactly in boundary cycle bypasses pending; last write wins
    wait_cyc(127);
    write(0, 4);
    check("t4_b_write_pending", pending, 0);
    expect_frame(4, 0, 1'b1, 32'h8080_8080, "t4_pat_ch0");
    expect_ones(4, 4, 26, 31, 0, "t4_f4");
    wait_cyc(140);
    write(0, 'h10);
    write(0, 'h11);
    check("t4_pending", pending, 4'b0001);
    expect_frame(5, 0, 1'b1, 32'hD555_AAAA, "t4_pat_ch0_last");

    // Test 5: out-of-range channel is ignored
    wait_cyc(170);
    write(5, 'h1f);
    check("t5_pending", pending, 0);
    expect_ones(5, 17, 26, 31, 0, "t5_f5");

    // Test 6: mid-frame reset with levels loaded and one write pending
    wait_cyc(196);
    write(3, 9);
    check("t6_pending_before", pending, 4'b1000);
    wait_cyc(200);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_async_dac_out", dac_out, 0);
    check("t6_async_pending", pending, 0);
    check("t6_async_frame_sync", frame_sync, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t6_rel_frame_sync", frame_sync, 1);
    check("t6_rel_dac_out", dac_out, 0);
    expect_ones(0, 0, 0, 0, 0, "t6_f0");
    wait_cyc(5);
    write(2, 6);
    check("t6_pending_new", pending, 4'b0100);
    expect_frame(1, 0, 1'b1, 32'h0000_0000, "t6_pat_ch0");
    expect_ones(1, 0, 0, 6, 0, "t6_f1");

    wait_cyc(66);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
